sipo_deser: RTL and testbench



---
 rtl/sipo_deser.sv | 127 ++++++++++++
 tb/tb_sipo_deser.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with frame realignment and overrun flag
//
// Collects WIDTH serial bits into a word and presents it through a one-entry
// holding register with a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   serial_in    serial data bit
//   serial_valid serial_in is sampled on this edge only when high
//   frame_start  with serial_valid, current bit becomes bit 0 of a new word
//   data_out     held word
//   data_valid   holding register contains an unconsumed word
//   data_ready   consumer accepts data_out when data_valid is also high
//   bit_cnt      bits accumulated in the current partial word
//   overrun      sticky, a completed word was dropped
//   overrun_clr  clears overrun on the next edge
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  input  logic                     serial_valid,
  input  logic                     frame_start,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   ONE_IDX  = CW'(1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;
  logic             realign;
  logic             complete;
  logic             hold_free;
  logic             pop;

  // Shift register after taking the current bit; on a completing edge this
  // is the finished word, current bit included.
  always_comb begin
    shifted    = '0;
    first_word = '0;
    if (LSB_FIRST != 0) begin
      shifted    = {serial_in, shift_q[WIDTH-1:1]};
      first_word = {serial_in, {(WIDTH-1){1'b0}}};
    end else begin
      shifted    = {shift_q[WIDTH-2:0], serial_in};
      first_word = {{(WIDTH-1){1'b0}}, serial_in};
    end
  end

  // Realignment outranks completion when both land on the same bit.
  assign realign   = serial_valid & frame_start;
  assign complete  = serial_valid & ~frame_start & (cnt_q == LAST_IDX);
  assign hold_free = ~valid_q | data_ready;
  assign pop       = valid_q & data_ready;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (realign) begin
      shift_d = first_word;
      cnt_d   = ONE_IDX;
    end else if (complete) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (serial_valid) begin
      shift_d = shifted;
      cnt_d   = cnt_q + ONE_IDX;
    end

    // A same-edge pop frees the slot, so the new word simply replaces the old.
    if (complete && hold_free) begin
      data_d  = shifted;
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end

    // Setting wins over a simultaneous clear.
    if (complete && !hold_free) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - randomized self-checking bench for sipo_deser (both bit orders)
module tb_sipo_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         data_ready = 1'b0;
  logic         overrun_clr = 1'b0;

  logic [W-1:0] dout_l, dout_m;
  logic         dv_l, dv_m;
  logic [2:0]   cnt_l, cnt_m;
  logic         ovr_l, ovr_m;

  int total = 0;
  int bad   = 0;

  // Reference model: partial word kept as a list of received bits.
  bit           part[$];
  logic [W-1:0] m_held_l = '0;
  logic [W-1:0] m_held_m = '0;
  logic         m_hv  = 1'b0;
  logic         m_ovr = 1'b0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .data_out(dout_l), .data_valid(dv_l),
    .data_ready(data_ready), .bit_cnt(cnt_l), .overrun(ovr_l),
    .overrun_clr(overrun_clr)
  );

  sipo_deser #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .data_out(dout_m), .data_valid(dv_m),
    .data_ready(data_ready), .bit_cnt(cnt_m), .overrun(ovr_m),
    .overrun_clr(overrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word from the bit list: first received bit is bit 0 (LSB-first) or bit W-1.
  function automatic logic [W-1:0] form(input bit msb_first);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb_first) w[W-1-i] = part[i];
      else           w[i]     = part[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    part.delete();
    m_held_l = '0;
    m_held_m = '0;
    m_hv     = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_edge(input logic sin, input logic sv, input logic fs,
                            input logic rdy, input logic clr);
    bit stored  = 1'b0;
    bit set_ovr = 1'b0;
    if (sv) begin
      if (fs) begin
        part.delete();
        part.push_back(sin);
      end else begin
        part.push_back(sin);
        if (part.size() == W) begin
          if (!m_hv || rdy) begin
            m_held_l = form(1'b0);
            m_held_m = form(1'b1);
            m_hv     = 1'b1;
            stored   = 1'b1;
          end else begin
            set_ovr = 1'b1;
          end
          part.delete();
        end
      end
    end
    if (!stored && m_hv && rdy) m_hv = 1'b0;
    if (set_ovr)  m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic compare_all();
    check("valid_l", {31'b0, dv_l}, {31'b0, m_hv});
    check("valid_m", {31'b0, dv_m}, {31'b0, m_hv});
    check("cnt_l", {29'b0, cnt_l}, part.size());
    check("cnt_m", {29'b0, cnt_m}, part.size());
    check("ovr_l", {31'b0, ovr_l}, {31'b0, m_ovr});
    check("ovr_m", {31'b0, ovr_m}, {31'b0, m_ovr});
    check("data_l", {24'b0, dout_l}, {24'b0, m_held_l});
    check("data_m", {24'b0, dout_m}, {24'b0, m_held_m});
  endtask

  task automatic step(input logic sin, input logic sv, input logic fs,
                      input logic rdy, input logic clr);
    serial_in    = sin;
    serial_valid = sv;
    frame_start  = fs;
    data_ready   = rdy;
    overrun_clr  = clr;
    @(posedge clk);
    model_edge(sin, sv, fs, rdy, clr);
    #1;
    compare_all();
  endtask

  // Idle cycle; frame_start is randomized since it must be ignored without serial_valid.
  task automatic idle(input logic rdy, input logic clr);
    step(1'($urandom), 1'b0, 1'($urandom), rdy, clr);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit msb_order, input bit fs_first,
                           input logic rdy_body, input logic rdy_last, input int max_gap);
    for (int i = 0; i < W; i++) begin
      logic b;
      int   g;
      b = msb_order ? w[W-1-i] : w[i];
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int k = 0; k < g; k++) idle(rdy_body, 1'b0);
      step(b, 1'b1, (fs_first && i == 0), (i == W-1) ? rdy_last : rdy_body, 1'b0);
    end
  endtask

  task automatic drain();
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #1;
    compare_all();
    check("rst_data_l", {24'b0, dout_l}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1'b1, 1'b0);

    // 1: LSB-first 0xA5, valid for one cycle with ready held high
    send_word(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check("t1_word_l", {24'b0, dout_l}, 32'hA5);
    check("t1_word_m", {24'b0, dout_m}, 32'hA5);
    check("t1_valid", {31'b0, dv_l}, 32'h1);
    idle(1'b1, 1'b0);
    check("t1_valid_drop", {31'b0, dv_l}, 32'h0);

    // 2: 0x0F sent MSB first
    send_word(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    check("t2_word_m", {24'b0, dout_m}, 32'h0F);
    check("t2_word_l", {24'b0, dout_l}, 32'hF0);
    drain();

    // 3: overrun with ready low, then clear and consume
    send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("t3_kept", {24'b0, dout_l}, 32'h3C);
    check("t3_ovr", {31'b0, ovr_l}, 32'h1);
    idle(1'b0, 1'b1);
    check("t3_ovr_clr", {31'b0, ovr_l}, 32'h0);
    idle(1'b1, 1'b0);
    check("t3_consumed", {31'b0, dv_l}, 32'h0);

    // 4: pop on the completing edge replaces the word without overrun
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check("t4_word", {24'b0, dout_l}, 32'h22);
    check("t4_valid", {31'b0, dv_l}, 32'h1);
    check("t4_ovr", {31'b0, ovr_l}, 32'h0);
    drain();

    // 5: garbage then realignment, without and with gaps
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
      send_word(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, r * 3);
      check("t5_word", {24'b0, dout_l}, 32'h5A);
      check("t5_ovr", {31'b0, ovr_l}, 32'h0);
      drain();
    end
    // realign on the bit that would have completed a word
    for (int i = 0; i < W-1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_no_complete", {31'b0, dv_l}, 32'h0);
    check("t5_cnt", {29'b0, cnt_l}, 32'h1);
    drain();
    model_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1 rst = 1'b0;

    // 6: asynchronous reset mid-word with a held word
    send_word(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_pre_cnt", {29'b0, cnt_l}, 32'h4);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t6_data", {24'b0, dout_l}, 32'h0);
    check("t6_valid", {31'b0, dv_l}, 32'h0);
    check("t6_cnt", {29'b0, cnt_l}, 32'h0);
    check("t6_ovr", {31'b0, ovr_m}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    check("t6_after", {24'b0, dout_l}, 32'h81);
    drain();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
